ahb_sram_subordinate: RTL



---
 rtl/ahb_pkg.sv | 13 +
 rtl/ahb_sram_array.sv | 18 +
 rtl/ahb_sram_subordinate.sv | 94 +++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer types, response codes and byte-lane decode
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} htrans_e;
  typedef enum logic [2:0] {BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2, DWORD = 3'd3} hsize_e;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  function automatic logic [7:0] ahb_byte_enables(input logic [2:0] hsize, input logic [2:0] addr_lsbs,
                                                  input int unsigned nbytes);
    logic [7:0] m;
    m = (hsize == 3'd0) ? 8'h01 : (hsize == 3'd1) ? 8'h03 : (hsize == 3'd2) ? 8'h0f : 8'hff;
    return m << (addr_lsbs & 3'(nbytes - 1));
  endfunction
endpackage

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: single-port word array with byte-enable write and combinational read
module ahb_sram_array #(
  parameter int DepthWords = 1024,
  parameter int DataWidth = 32
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [DataWidth/8-1:0]        i_be,
  input  logic [$clog2(DepthWords)-1:0] i_idx,
  input  logic [DataWidth-1:0]          i_wdata,
  output logic [DataWidth-1:0]          o_rdata
);
  logic [DataWidth-1:0] r_mem [DepthWords];
  always_ff @(posedge clk)
    for (int b = 0; b < DataWidth/8; b++)
      if (i_we && i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate: AHB-Lite SRAM target with programmable wait states and
// two-cycle ERROR responses for out-of-range, oversized or misaligned transfers
module ahb_sram_subordinate
  import ahb_pkg::*;
#(
  parameter int                      AddressWidth = 32,
  parameter int                      DataWidth    = 32,
  parameter int                      DepthWords   = 1024,
  parameter logic [AddressWidth-1:0] BaseAddress  = '0,
  parameter int                      WaitStates   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hsel,
  input  logic [AddressWidth-1:0] haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [DataWidth-1:0]    hwdata,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DataWidth-1:0]    hrdata
);
  localparam int NB = DataWidth / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DepthWords);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
  state_e r_state, w_next;
  logic [3:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic [LB-1:0] r_lsb;
  logic [2:0] r_size;
  logic r_write, r_hreadyout, r_hresp;
  logic [AddressWidth-1:0] w_off;
  logic [LB-1:0] w_amask;
  logic [NB-1:0] w_be;
  logic [DataWidth-1:0] w_rdata;
  logic w_accept, w_in_range, w_size_ok, w_aligned, w_legal, w_open, w_we, w_unused;
  assign w_unused = ^{hburst, htrans[0]};
  assign w_off = haddr - BaseAddress;
  assign w_in_range = (haddr >= BaseAddress) && (64'(w_off) < 64'(DepthWords) * 64'(NB));
  assign w_size_ok = hsize <= 3'(LB);
  assign w_amask = LB'((8'd1 << hsize) - 8'd1);
  assign w_aligned = (haddr[LB-1:0] & w_amask) == '0;
  assign w_legal = w_in_range && w_size_ok && w_aligned;
  assign w_accept = hsel && hready && htrans[1];
  // states where hreadyout is high, so the bus may present a new address phase
  assign w_open = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  always_comb begin
    w_next = r_state;
    if (w_open) w_next = !w_accept ? S_IDLE : !w_legal ? S_ERR1 : (WaitStates > 0) ? S_WAIT : S_DATA;
    else if (r_state == S_ERR1) w_next = S_ERR2;
    else if (r_cnt == 4'd1) w_next = S_DATA;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_idx       <= '0;
      r_lsb       <= '0;
      r_size      <= '0;
      r_write     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hreadyout <= !((w_next == S_WAIT) || (w_next == S_ERR1));
      r_hresp     <= ((w_next == S_ERR1) || (w_next == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      r_cnt       <= (w_open && w_accept) ? 4'(WaitStates) : (r_state == S_WAIT) ? r_cnt - 4'd1 : r_cnt;
      if (w_open && w_accept) begin
        r_idx   <= AW'(w_off >> LB);
        r_lsb   <= haddr[LB-1:0];
        r_size  <= hsize;
        r_write <= hwrite;
      end
    end
  end
  // a reset landing in a write data phase abandons the write
  assign w_we = (r_state == S_DATA) && r_write && !rst;
  assign w_be = NB'(ahb_byte_enables(r_size, 3'(r_lsb), NB));
  ahb_sram_array #(.DepthWords(DepthWords), .DataWidth(DataWidth)) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_idx  (r_idx),
    .i_wdata(hwdata),
    .o_rdata(w_rdata)
  );
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = ((r_state == S_DATA) && !r_write) ? w_rdata : '0;
endmodule
